// File: rtl/instruction_fetch_unit.sv
// IF stage of the RV32IM pipeline: owns the fetch PC, drives the instruction memory port
// and loads the IF/ID register, redirecting fetch and killing wrong-path work on taken branches.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic        imem_busywait_i,
    input  logic [31:0] imem_readdata_i,
    output logic        imem_read_o,
    output logic [31:0] imem_address_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instruction_o,
    output logic        if_valid_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] ptgt_q, ptgt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        read_q, read_d;

    logic [31:0] target_aligned;
    logic [31:0] fpc_plus4;

    assign target_aligned = branch_target_i & 32'hFFFF_FFFC;
    assign fpc_plus4      = fpc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        ptgt_d     = ptgt_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        flush_d    = 1'b0;
        read_d     = read_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                read_d  = 1'b1;
            end

            FETCH: begin
                if (branch_taken_i) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    flush_d = 1'b1;
                    if (imem_busywait_i) begin
                        // The miss in flight must complete at its own address before we can redirect.
                        ptgt_d  = target_aligned;
                        state_d = REDIRECT;
                    end else begin
                        fpc_d = target_aligned;
                    end
                end else if (stall_i) begin
                    flush_d = 1'b0;
                end else if (imem_busywait_i) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else begin
                    pc_d       = fpc_q;
                    pc_plus4_d = fpc_plus4;
                    instr_d    = imem_readdata_i;
                    valid_d    = 1'b1;
                    fpc_d      = fpc_plus4;
                end
            end

            REDIRECT: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                if (branch_taken_i) begin
                    ptgt_d  = target_aligned;
                    flush_d = 1'b1;
                end
                // Returned stale word is dropped; the youngest taken target wins.
                if (!imem_busywait_i) begin
                    fpc_d   = branch_taken_i ? target_aligned : ptgt_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            fpc_q      <= RESET_PC & 32'hFFFF_FFFC;
            ptgt_q     <= 32'h0000_0000;
            pc_q       <= 32'h0000_0000;
            pc_plus4_q <= 32'h0000_0000;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            ptgt_q     <= ptgt_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            read_q     <= read_d;
        end
    end

    assign imem_read_o    = read_q;
    assign imem_address_o = fpc_q;
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4_q;
    assign instruction_o  = instr_q;
    assign if_valid_o     = valid_q;
    assign flush_o        = flush_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of the fetch stage kept in this file.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rstN;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        stall;
    logic        busywait;
    logic [31:0] readData;
    logic        imemRead;
    logic [31:0] imemAddress;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4Out;
    logic [31:0] instrOut;
    logic        ifValid;
    logic        flushOut;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: mode 0 = waiting after reset, 1 = fetching, 2 = waiting to redirect.
    int          mMode;
    logic [31:0] mFpc, mTarget;
    logic        eRead, eValid, eFlush;
    logic [31:0] ePc, ePc4, eInstr;

    instruction_fetch_unit dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .branch_taken_i  (branchTaken),
        .branch_target_i (branchTarget),
        .stall_i         (stall),
        .imem_busywait_i (busywait),
        .imem_readdata_i (readData),
        .imem_read_o     (imemRead),
        .imem_address_o  (imemAddress),
        .pc_o            (pcOut),
        .pc_plus4_o      (pcPlus4Out),
        .instruction_o   (instrOut),
        .if_valid_o      (ifValid),
        .flush_o         (flushOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A00_0013;
    endfunction

    function automatic logic [130:0] obsVec();
        return {imemRead, imemAddress, pcOut, pcPlus4Out, instrOut, ifValid, flushOut};
    endfunction

    function automatic logic [130:0] expVec();
        return {eRead, mFpc, ePc, ePc4, eInstr, eValid, eFlush};
    endfunction

    // Behavioural view of one clock edge, written from the stage's rules.
    task automatic modelEdge(input logic rst, input logic br, input logic [31:0] tgt,
                             input logic st, input logic bz);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (!rst) begin
            mMode = 0; mFpc = 32'h0; mTarget = 32'h0;
            eRead = 0; eValid = 0; eFlush = 0; ePc = 0; ePc4 = 0; eInstr = NOP;
            return;
        end
        if (mMode == 0) begin
            mMode = 1; eRead = 1; eFlush = 0;
        end else if (mMode == 1) begin
            eFlush = br;
            if (br) begin
                eValid = 0; eInstr = NOP;
                if (bz) begin mTarget = t; mMode = 2; end
                else mFpc = t;
            end else if (!st) begin
                if (bz) begin
                    eValid = 0; eInstr = NOP;
                end else begin
                    ePc = mFpc; ePc4 = mFpc + 32'd4; eInstr = memWord(mFpc);
                    eValid = 1; mFpc = mFpc + 32'd4;
                end
            end
        end else begin
            eFlush = br; eValid = 0; eInstr = NOP;
            if (br) mTarget = t;
            if (!bz) begin mFpc = mTarget; mMode = 1; end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic br, input logic [31:0] tgt,
                                 input logic st, input logic bz);
        rstN         = rst;
        branchTaken  = br;
        branchTarget = tgt;
        stall        = st;
        busywait     = bz;
        readData     = bz ? $urandom : memWord(imemAddress);
        @(posedge clk);
        modelEdge(rst, br, tgt, st, bz);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h1234, 1, 1);
        testsRun++;
        if (obsVec() !== {1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_values got=%h want=%h", obsVec(), {1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0});
        end
        applyStimulus(1, 0, 0, 0, 0);
        testsRun++;
        if (imemRead !== 1'b1 || imemAddress !== 32'h0 || ifValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release read=%b addr=%h valid=%b want 1/0/0", imemRead, imemAddress, ifValid);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            testsRun++;
            if (imemAddress !== 32'(4 * (i + 1)) || pcOut !== 32'(4 * i) || ifValid !== 1'b1 ||
                instrOut !== memWord(32'(4 * i)) || obsVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL seq_fetch_%0d got addr=%h pc=%h valid=%b instr=%h want addr=%h pc=%h",
                         i, imemAddress, pcOut, ifValid, instrOut, 32'(4 * (i + 1)), 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 16 && mFpc != 32'h20; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h0000_0103, 0, 0);
        testsRun++;
        if (flushOut !== 1'b1 || ifValid !== 1'b0 || imemAddress !== 32'h100 || instrOut !== NOP) begin
            testsFailed++;
            $display("[TB] FAIL branch_flush got flush=%b valid=%b addr=%h instr=%h want 1/0/00000100/%h",
                     flushOut, ifValid, imemAddress, instrOut, NOP);
        end
        applyStimulus(1, 0, 0, 0, 0);
        testsRun++;
        if (flushOut !== 1'b0 || ifValid !== 1'b1 || pcOut !== 32'h100 || pcPlus4Out !== 32'h104) begin
            testsFailed++;
            $display("[TB] FAIL branch_target got flush=%b valid=%b pc=%h pc4=%h want 0/1/100/104",
                     flushOut, ifValid, pcOut, pcPlus4Out);
        end
    endtask

    task automatic test_stall();
        applyStimulus(1, 1, 32'h40, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 1, 0);
            testsRun++;
            if (pcOut !== 32'h40 || ifValid !== 1'b1 || imemAddress !== 32'h44 || flushOut !== 1'b0 ||
                instrOut !== memWord(32'h40)) begin
                testsFailed++;
                $display("[TB] FAIL stall_hold_%0d got pc=%h valid=%b addr=%h flush=%b want 40/1/44/0",
                         i, pcOut, ifValid, imemAddress, flushOut);
            end
        end
        applyStimulus(1, 1, 32'h80, 1, 0);
        testsRun++;
        if (flushOut !== 1'b1 || imemAddress !== 32'h80 || ifValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stall_branch got flush=%b addr=%h valid=%b want 1/80/0", flushOut, imemAddress, ifValid);
        end
        applyStimulus(1, 0, 0, 0, 0);
        testsRun++;
        if (pcOut !== 32'h80 || ifValid !== 1'b1 || obsVec() !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL stall_resume got pc=%h valid=%b want 80/1", pcOut, ifValid);
        end
    endtask

    task automatic test_miss();
        logic [31:0] firstPc;
        logic        seen;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 1, 32'h200, 0, 1);
        testsRun++;
        if (flushOut !== 1'b1 || ifValid !== 1'b0 || obsVec() !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL miss_flush got flush=%b valid=%b want 1/0", flushOut, ifValid);
        end
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1);
        testsRun++;
        if (flushOut !== 1'b0 || ifValid !== 1'b0 || obsVec() !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL miss_wait got flush=%b valid=%b addr=%h", flushOut, ifValid, imemAddress);
        end
        seen = 0; firstPc = 32'hDEAD_BEEF;
        for (int i = 0; i < 6 && !seen; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            if (ifValid) begin seen = 1; firstPc = pcOut; end
        end
        testsRun++;
        if (!seen || firstPc !== 32'h200) begin
            testsFailed++;
            $display("[TB] FAIL miss_first_valid got seen=%b pc=%h want 1/00000200", seen, firstPc);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1, 1, 32'h500, 0, 0);
        applyStimulus(1, 1, 32'h604, 0, 0);
        testsRun++;
        if (flushOut !== 1'b1 || imemAddress !== 32'h604 || obsVec() !== expVec()) begin
            testsFailed++;
            $display("[TB] FAIL b2b_branch got flush=%b addr=%h want 1/604", flushOut, imemAddress);
        end
        applyStimulus(1, 0, 0, 0, 0);
        testsRun++;
        if (pcOut !== 32'h604 || ifValid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_target got pc=%h valid=%b want 604/1", pcOut, ifValid);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(1, 1, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        testsRun++;
        if (pcOut !== 32'hFFFF_FFFC || pcPlus4Out !== 32'h0 || imemAddress !== 32'h0 || ifValid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrap got pc=%h pc4=%h addr=%h valid=%b want fffffffc/0/0/1",
                     pcOut, pcPlus4Out, imemAddress, ifValid);
        end
    endtask

    task automatic test_reset_redirect();
        applyStimulus(1, 1, 32'h300, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 1, 32'h700, 0, 1);
        testsRun++;
        if (obsVec() !== {1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL redirect_reset got=%h", obsVec());
        end
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        testsRun++;
        if (pcOut !== 32'h0 || ifValid !== 1'b1 || imemAddress !== 32'h4) begin
            testsFailed++;
            $display("[TB] FAIL redirect_restart got pc=%h valid=%b addr=%h want 0/1/4", pcOut, ifValid, imemAddress);
        end
    endtask

    task automatic test_random();
        logic        r, b, s, w;
        logic [31:0] t;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 63) != 0);
            b = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 5) == 0);
            w = ($urandom_range(0, 3) == 0);
            t = $urandom;
            applyStimulus(r, b, t, s, w);
            testsRun++;
            if (obsVec() !== expVec()) begin
                testsFailed++;
                $display("[TB] FAIL random_%0d got=%h want=%h", i, obsVec(), expVec());
            end
        end
    endtask

    initial begin
        rstN = 0; branchTaken = 0; branchTarget = 0; stall = 0; busywait = 0; readData = 0;
        mMode = 0; mFpc = 0; mTarget = 0;
        eRead = 0; eValid = 0; eFlush = 0; ePc = 0; ePc4 = 0; eInstr = NOP;
        @(negedge clk);
        test_reset();
        test_branch();
        test_stall();
        test_miss();
        test_back_to_back();
        test_wrap();
        test_reset_redirect();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
